// File: rtl/pwm_pkg.sv
// Shared constants and the duty clamp used by the PWM output stage.
package pwm_pkg;

  localparam int PWM_STEPS = 100;
  localparam int DUTY_W    = 7;

  localparam logic [DUTY_W-1:0] DUTY_MAX  = DUTY_W'(100);
  localparam logic [DUTY_W-1:0] STEP_LAST = DUTY_W'(PWM_STEPS - 1);

  // Requests above 100 % saturate at 100 %.
  function automatic logic [DUTY_W-1:0] clamp_duty(input logic [DUTY_W-1:0] duty);
    return (duty > DUTY_MAX) ? DUTY_MAX : duty;
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Divides clk into PWM steps: tick_o marks the last clk of each step.
module pwm_prescaler #(
  parameter int PRESCALE_DIV = 500
) (
  input  logic clk,
  input  logic rst_i,
  input  logic en_i,
  output logic tick_o,
  output logic presc_zero_o
);

  localparam int CNT_W = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE_DIV - 1);

  logic [CNT_W-1:0] presc_cnt;

  assign tick_o       = en_i && (presc_cnt == CNT_LAST);
  assign presc_zero_o = (presc_cnt == '0);

  // Prescaler counter: held at 0 while idle, wraps after PRESCALE_DIV clks.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      presc_cnt <= '0;
    end else if (!en_i || tick_o) begin
      presc_cnt <= '0;
    end else begin
      presc_cnt <= presc_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pwm_gen.sv
// Fixed-frequency PWM stage with a shadowed percent duty, applied only at wraps.
module pwm_gen
  import pwm_pkg::*;
#(
  parameter int PRESCALE_DIV = 500
) (
  input  logic              clk,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic [DUTY_W-1:0] duty_i,
  output logic              pwm_o,
  output logic              period_start_o,
  output logic [DUTY_W-1:0] duty_active_o
);

  logic              tick;
  logic              presc_zero;
  logic [DUTY_W-1:0] step_cnt;
  logic [DUTY_W-1:0] duty_active;
  logic [DUTY_W-1:0] dclamp;

  assign dclamp        = clamp_duty(duty_i);
  assign duty_active_o = duty_active;

  pwm_prescaler #(
    .PRESCALE_DIV (PRESCALE_DIV)
  ) u_prescaler (
    .clk          (clk),
    .rst_i        (rst_i),
    .en_i         (en_i),
    .tick_o       (tick),
    .presc_zero_o (presc_zero)
  );

  // Step counter and duty shadow: the shadow follows the request while idle
  // and otherwise reloads only when the step counter wraps.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      step_cnt    <= '0;
      duty_active <= '0;
    end else if (!en_i) begin
      step_cnt    <= '0;
      duty_active <= dclamp;
    end else if (tick) begin
      if (step_cnt == STEP_LAST) begin
        step_cnt    <= '0;
        duty_active <= dclamp;
      end else begin
        step_cnt <= step_cnt + DUTY_W'(1);
      end
    end
  end

  // Registered outputs, one clk behind the counter state they decode.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      pwm_o          <= 1'b0;
      period_start_o <= 1'b0;
    end else begin
      pwm_o          <= en_i && (step_cnt < duty_active);
      period_start_o <= en_i && (step_cnt == '0) && presc_zero;
    end
  end

endmodule

// File: tb/tb_pwm_gen.sv
// Directed bench for pwm_gen with PRESCALE_DIV=2 (200 clk per period).
module tb_pwm_gen;

  localparam int DIV    = 2;
  localparam int PERIOD = 100 * DIV;

  logic       clk;
  logic       rst_i;
  logic       en_i;
  logic [6:0] duty_i;
  logic       pwm_o;
  logic       period_start_o;
  logic [6:0] duty_active_o;

  int errors = 0;
  int checks = 0;

  pwm_gen #(
    .PRESCALE_DIV (DIV)
  ) dut (
    .clk            (clk),
    .rst_i          (rst_i),
    .en_i           (en_i),
    .duty_i         (duty_i),
    .pwm_o          (pwm_o),
    .period_start_o (period_start_o),
    .duty_active_o  (duty_active_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [6:0] duty;
    int         exp_active;
    int         exp_high;
    int         periods;
    string      name;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Enters from idle, enables, checks the pulse train for whole periods, then disables.
  task automatic run_vector(input logic [6:0] d, input int exp_active, input int exp_high,
                            input int periods, input string tag);
    int   high_cnt = 0;
    int   ps_cnt   = 0;
    int   pat_err  = 0;
    logic exp_pwm;
    logic exp_ps;
    duty_i = d;
    repeat (2) @(negedge clk);
    check({tag, " idle duty_active"}, duty_active_o, exp_active);
    en_i = 1'b1;
    @(negedge clk);
    check({tag, " period_start at E+1"}, period_start_o, 1);
    for (int i = 0; i < periods * PERIOD; i++) begin
      if (i > 0) @(negedge clk);
      exp_pwm = ((i % PERIOD) < exp_high);
      exp_ps  = ((i % PERIOD) == 0);
      high_cnt += int'(pwm_o);
      ps_cnt   += int'(period_start_o);
      if (pwm_o !== exp_pwm || period_start_o !== exp_ps) pat_err++;
    end
    check({tag, " high clks"}, high_cnt, periods * exp_high);
    check({tag, " period pulses"}, ps_cnt, periods);
    check({tag, " waveform errors"}, pat_err, 0);
    check({tag, " duty_active"}, duty_active_o, exp_active);
    en_i = 1'b0;
    @(negedge clk);
    check({tag, " pwm after disable"}, pwm_o, 0);
    check({tag, " start after disable"}, period_start_o, 0);
  endtask

  initial begin
    int hi0;
    int hi1;

    vecs[0] = '{7'd30,  30,  60, 2, "duty30"};
    vecs[1] = '{7'd0,    0,   0, 3, "duty0"};
    vecs[2] = '{7'd100, 100, 200, 3, "duty100"};
    vecs[3] = '{7'd127, 100, 200, 2, "clamp127"};
    vecs[4] = '{7'd101, 100, 200, 1, "clamp101"};
    vecs[5] = '{7'd1,    1,   2, 1, "duty1"};
    vecs[6] = '{7'd99,  99, 198, 2, "duty99"};
    vecs[7] = '{7'd50,  50, 100, 1, "duty50"};

    rst_i  = 1'b1;
    en_i   = 1'b0;
    duty_i = 7'd55;
    repeat (2) @(negedge clk);
    check("reset pwm", pwm_o, 0);
    check("reset period_start", period_start_o, 0);
    check("reset duty_active", duty_active_o, 0);
    rst_i = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 8; v++) begin
      run_vector(vecs[v].duty, vecs[v].exp_active, vecs[v].exp_high, vecs[v].periods, vecs[v].name);
    end

    // Shadowing: request changes to 70 at step 50 of the first period.
    duty_i = 7'd30;
    repeat (2) @(negedge clk);
    en_i = 1'b1;
    hi0 = 0;
    hi1 = 0;
    for (int i = 0; i < 2 * PERIOD; i++) begin
      @(negedge clk);
      if (i < PERIOD) hi0 += int'(pwm_o);
      else            hi1 += int'(pwm_o);
      if (i == 100) duty_i = 7'd70;
      if (i == 198) check("shadow duty before wrap", duty_active_o, 30);
      if (i == 199) check("shadow duty at wrap", duty_active_o, 70);
      if (i == 199) check("shadow no start before wrap", period_start_o, 0);
      if (i == 200) check("shadow start after wrap", period_start_o, 1);
    end
    check("shadow first period high", hi0, 60);
    check("shadow second period high", hi1, 140);
    en_i = 1'b0;
    @(negedge clk);

    // Enable toggle: drop en_i during the high phase, restart at 50 %.
    duty_i = 7'd30;
    repeat (2) @(negedge clk);
    en_i = 1'b1;
    repeat (21) @(negedge clk);
    check("toggle pwm high before drop", pwm_o, 1);
    en_i = 1'b0;
    @(negedge clk);
    check("toggle pwm after drop", pwm_o, 0);
    check("toggle start after drop", period_start_o, 0);
    run_vector(7'd50, 50, 100, 1, "restart50");

    // Asynchronous reset mid-period, between clock edges.
    duty_i = 7'd30;
    repeat (2) @(negedge clk);
    en_i = 1'b1;
    repeat (30) @(negedge clk);
    check("pre-reset pwm", pwm_o, 1);
    check("pre-reset duty_active", duty_active_o, 30);
    @(posedge clk);
    #2 rst_i = 1'b1;
    #1;
    check("async reset pwm", pwm_o, 0);
    check("async reset period_start", period_start_o, 0);
    check("async reset duty_active", duty_active_o, 0);
    @(negedge clk);
    check("held reset pwm", pwm_o, 0);
    check("held reset duty_active", duty_active_o, 0);
    en_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    check("post-reset idle duty_active", duty_active_o, 30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
